// File: rtl/jogo_pkg.sv
// jogo_pkg: FSM state type, screen/object dimensions and score helper shared by the
// collision detector and the obstacle generator.
package jogo_pkg;

   typedef enum logic [1:0] {JOGANDO, INVULNERAVEL, FIM_JOGO, REINICIO} estado_t;

   localparam int TELA_LARGURA = 640;
   localparam int TELA_ALTURA  = 480;
   localparam int CAR_LARG_PAD = 40;
   localparam int CAR_ALT_PAD  = 60;
   localparam int OBS_LARG_PAD = 50;
   localparam int OBS_ALT_PAD  = 50;
   localparam int VIDAS_MAX    = 3;

   function automatic logic [15:0] soma_sat(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + 17'(b);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/detector_colisao_if.sv
// detector_colisao_if: positions/button in, game status out.
interface detector_colisao_if;
   logic        frame_tick;
   logic [9:0]  car_h_pos;
   logic [8:0]  car_v_pos;
   logic [9:0]  obs1_h_pos;
   logic [8:0]  obs1_v_pos;
   logic [9:0]  obs2_h_pos;
   logic [8:0]  obs2_v_pos;
   logic        btn_start;
   logic        reset_game;
   logic        game_over;
   logic [1:0]  lives;
   logic        hit_flash;
   logic [15:0] score;

   modport slave (
      input  frame_tick, car_h_pos, car_v_pos, obs1_h_pos, obs1_v_pos,
             obs2_h_pos, obs2_v_pos, btn_start,
      output reset_game, game_over, lives, hit_flash, score
   );

   modport master (
      output frame_tick, car_h_pos, car_v_pos, obs1_h_pos, obs1_v_pos,
             obs2_h_pos, obs2_v_pos, btn_start,
      input  reset_game, game_over, lives, hit_flash, score
   );
endinterface

// File: rtl/caixa_sobreposicao.sv
// caixa_sobreposicao: strict axis-aligned box overlap; shared edges do not count.
module caixa_sobreposicao #(
   parameter int A_LARG = 40,
   parameter int A_ALT  = 60,
   parameter int B_LARG = 50,
   parameter int B_ALT  = 50
) (
   input  logic [9:0] a_h_i,
   input  logic [8:0] a_v_i,
   input  logic [9:0] b_h_i,
   input  logic [8:0] b_v_i,
   output logic       sobrepoe_o
);
   // 11-bit so right/bottom edges near the screen limit cannot wrap
   assign sobrepoe_o = (11'(a_h_i) < 11'(b_h_i) + 11'(B_LARG)) &&
                       (11'(b_h_i) < 11'(a_h_i) + 11'(A_LARG)) &&
                       (11'(a_v_i) < 11'(b_v_i) + 11'(B_ALT))  &&
                       (11'(b_v_i) < 11'(a_v_i) + 11'(A_ALT));
endmodule

// File: rtl/detector_colisao.sv
// detector_colisao: car/obstacle collision, lives and invulnerability FSM with restart.
// Define PLACAR_EN to build the obstacle-wrap score counter; otherwise score is 0.
module detector_colisao
   import jogo_pkg::*;
#(
   parameter int CAR_LARGURA  = CAR_LARG_PAD,
   parameter int CAR_ALTURA   = CAR_ALT_PAD,
   parameter int OBS_LARGURA  = OBS_LARG_PAD,
   parameter int OBS_ALTURA   = OBS_ALT_PAD,
   parameter int VIDAS_INI    = VIDAS_MAX,
   parameter int INVUL_FRAMES = 60
) (
   input logic                iVGA_CLK,
   input logic                iRST,
   detector_colisao_if.slave  bus
);
   localparam int CW = $clog2(INVUL_FRAMES + 2);

   estado_t       estado_q;
   logic [1:0]    vidas_q;
   logic [CW-1:0] cont_q;
   logic          game_over_q, reset_game_q, hit_flash_q, btn_q;
   logic          sob1, sob2, hit, reiniciar;

   caixa_sobreposicao #(
      .A_LARG(CAR_LARGURA), .A_ALT(CAR_ALTURA), .B_LARG(OBS_LARGURA), .B_ALT(OBS_ALTURA)
   ) u_obs1 (
      .a_h_i(bus.car_h_pos), .a_v_i(bus.car_v_pos),
      .b_h_i(bus.obs1_h_pos), .b_v_i(bus.obs1_v_pos), .sobrepoe_o(sob1)
   );

   caixa_sobreposicao #(
      .A_LARG(CAR_LARGURA), .A_ALT(CAR_ALTURA), .B_LARG(OBS_LARGURA), .B_ALT(OBS_ALTURA)
   ) u_obs2 (
      .a_h_i(bus.car_h_pos), .a_v_i(bus.car_v_pos),
      .b_h_i(bus.obs2_h_pos), .b_v_i(bus.obs2_v_pos), .sobrepoe_o(sob2)
   );

   assign hit       = bus.frame_tick && (sob1 || sob2);
   assign reiniciar = (estado_q == FIM_JOGO) && bus.btn_start && !btn_q;

   always_ff @(posedge iVGA_CLK or posedge iRST) begin
      if (iRST) begin
         estado_q     <= JOGANDO;
         vidas_q      <= 2'(VIDAS_INI);
         cont_q       <= '0;
         game_over_q  <= 1'b0;
         reset_game_q <= 1'b0;
         hit_flash_q  <= 1'b0;
         btn_q        <= 1'b0;
      end else begin
         btn_q        <= bus.btn_start;
         reset_game_q <= 1'b0;
         case (estado_q)
            JOGANDO:
               if (hit) begin
                  vidas_q <= vidas_q - 2'd1;
                  if (vidas_q == 2'd1) begin
                     estado_q    <= FIM_JOGO;
                     game_over_q <= 1'b1;
                  end else begin
                     estado_q    <= INVULNERAVEL;
                     cont_q      <= CW'(INVUL_FRAMES);
                     hit_flash_q <= 1'b1;
                  end
               end
            INVULNERAVEL:
               if (bus.frame_tick) begin
                  cont_q <= cont_q - CW'(1);
                  if (cont_q <= CW'(1)) begin
                     estado_q    <= JOGANDO;
                     hit_flash_q <= 1'b0;
                  end
               end
            FIM_JOGO:
               if (reiniciar) begin
                  estado_q     <= REINICIO;
                  reset_game_q <= 1'b1;
                  vidas_q      <= 2'(VIDAS_INI);
                  game_over_q  <= 1'b0;
               end
            default: estado_q <= JOGANDO;
         endcase
      end
   end

   assign bus.reset_game = reset_game_q;
   assign bus.game_over  = game_over_q;
   assign bus.lives      = vidas_q;
   assign bus.hit_flash  = hit_flash_q;

`ifdef PLACAR_EN
   logic [8:0]  prev1_q, prev2_q;
   logic [15:0] score_q, score_d;
   logic [1:0]  voltas;

   // an obstacle wrapped when it reappears above its last sampled line
   assign voltas  = 2'(bus.obs1_v_pos < prev1_q) + 2'(bus.obs2_v_pos < prev2_q);
   assign score_d = soma_sat(score_q, voltas);

   always_ff @(posedge iVGA_CLK or posedge iRST) begin
      if (iRST) begin
         prev1_q <= '0;
         prev2_q <= '0;
         score_q <= '0;
      end else begin
         if (reiniciar)
            score_q <= '0;
         else if (bus.frame_tick && (estado_q == JOGANDO || estado_q == INVULNERAVEL))
            score_q <= score_d;
         if (estado_q == REINICIO || bus.frame_tick) begin
            prev1_q <= bus.obs1_v_pos;
            prev2_q <= bus.obs2_v_pos;
         end
      end
   end

   assign bus.score = score_q;
`else
   assign bus.score = '0;
`endif

endmodule
